// File: rtl/sos_scheduler.sv
// Sequencer that runs one sample through N_STAGES cascaded biquad sections on a shared engine.
// Optional feature macro: SOS_BYPASS_EN adds a 'bypass' input that routes a sample straight to data_out.
module sos_scheduler #(
    parameter int DATA_SIZE = 24,
    parameter int N_STAGES  = 4,
    parameter int STAGE_W   = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_trig,
    input  logic [DATA_SIZE-1:0] data_in,
`ifdef SOS_BYPASS_EN
    input  logic                 bypass,
`endif
    output logic                 eng_start,
    output logic [STAGE_W-1:0]   eng_stage,
    output logic [DATA_SIZE-1:0] eng_data_in,
    input  logic                 eng_done,
    input  logic [DATA_SIZE-1:0] eng_data_out,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 filter_done,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N_STAGES - 1);
    localparam logic [STAGE_W-1:0] STAGE_ONE  = STAGE_W'(1'b1);
    localparam logic [7:0]         TMO_LAST   = 8'(TIMEOUT - 1);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [STAGE_W-1:0]     stage_r;
    logic [STAGE_W-1:0]     stage_nxt_s;
    logic [DATA_SIZE-1:0]   work_r;
    logic [DATA_SIZE-1:0]   work_nxt_s;
    logic [7:0]             tmo_cnt_r;
    logic [7:0]             tmo_nxt_s;
    logic                   load_out_s;
    logic [DATA_SIZE-1:0]   out_val_s;
    logic                   tmo_hit_s;
    logic                   ovr_set_s;

    logic                   eng_start_r;
    logic [STAGE_W-1:0]     eng_stage_r;
    logic [DATA_SIZE-1:0]   eng_data_in_r;
    logic [DATA_SIZE-1:0]   data_out_r;
    logic                   filter_done_r;
    logic                   busy_r;
    logic                   overrun_r;
    logic                   timeout_err_r;

`ifdef SOS_BYPASS_EN
    logic                   bypass_r;
    logic                   bypass_nxt_s;
`endif

    assign ovr_set_s = sample_trig && (state_r != IDLE);

    // Next-state, stage/work update and output-load decode
    always_comb begin
        state_nxt_s = state_r;
        stage_nxt_s = stage_r;
        work_nxt_s  = work_r;
        tmo_nxt_s   = tmo_cnt_r;
        load_out_s  = 1'b0;
        out_val_s   = work_r;
        tmo_hit_s   = 1'b0;
`ifdef SOS_BYPASS_EN
        bypass_nxt_s = bypass_r;
`endif
        case (state_r)
            IDLE: begin
                if (sample_trig) begin
                    work_nxt_s  = data_in;
                    stage_nxt_s = '0;
`ifdef SOS_BYPASS_EN
                    bypass_nxt_s = bypass;
                    if (bypass) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = ISSUE;
                    end
`else
                    state_nxt_s = ISSUE;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                tmo_nxt_s   = 8'd0;
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    work_nxt_s = eng_data_out;
                    if (stage_r == LAST_STAGE) begin
                        // Result is registered on the way into DONE so data_out is visible during DONE
                        state_nxt_s = DONE;
                        load_out_s  = 1'b1;
                        out_val_s   = eng_data_out;
                    end else begin
                        stage_nxt_s = stage_r + STAGE_ONE;
                        state_nxt_s = ISSUE;
                    end
                end else if (tmo_cnt_r == TMO_LAST) begin
                    tmo_hit_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    tmo_nxt_s = tmo_cnt_r + 8'd1;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
`ifdef SOS_BYPASS_EN
                // Bypassed samples never visited WAIT, so the output load happens here instead
                if (bypass_r) begin
                    load_out_s = 1'b1;
                end else begin
                    load_out_s = 1'b0;
                end
`endif
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Sequencer state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            stage_r   <= '0;
            work_r    <= '0;
            tmo_cnt_r <= 8'd0;
`ifdef SOS_BYPASS_EN
            bypass_r  <= 1'b0;
`endif
        end else begin
            state_r   <= state_nxt_s;
            stage_r   <= stage_nxt_s;
            work_r    <= work_nxt_s;
            tmo_cnt_r <= tmo_nxt_s;
`ifdef SOS_BYPASS_EN
            bypass_r  <= bypass_nxt_s;
`endif
        end
    end

    // Registered engine handshake and result outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eng_start_r   <= 1'b0;
            eng_stage_r   <= '0;
            eng_data_in_r <= '0;
            data_out_r    <= '0;
            filter_done_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            eng_start_r   <= (state_nxt_s == ISSUE);
            filter_done_r <= load_out_s;
            busy_r        <= (state_nxt_s != IDLE);
            // Operand and bank select stay frozen from ISSUE until the engine answers
            if (state_nxt_s == ISSUE) begin
                eng_stage_r   <= stage_nxt_s;
                eng_data_in_r <= work_nxt_s;
            end else begin
                eng_stage_r   <= eng_stage_r;
                eng_data_in_r <= eng_data_in_r;
            end
            if (load_out_s) begin
                data_out_r <= out_val_s;
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    // Sticky error flags; a new error event takes priority over err_clr
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_r     <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (err_clr) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
            if (tmo_hit_s) begin
                timeout_err_r <= 1'b1;
            end else if (err_clr) begin
                timeout_err_r <= 1'b0;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    assign eng_start   = eng_start_r;
    assign eng_stage   = eng_stage_r;
    assign eng_data_in = eng_data_in_r;
    assign data_out    = data_out_r;
    assign filter_done = filter_done_r;
    assign busy        = busy_r;
    assign overrun     = overrun_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_sos_scheduler.sv
// Self-checking bench for sos_scheduler: behavioural engine (L=3, result = operand+1) plus
// scoreboard queues for expected engine issues and expected filter results.
module tb_sos_scheduler;

    localparam int DW  = 24;
    localparam int NS  = 4;
    localparam int SW  = 2;
    localparam int TMO = 64;
    localparam int L   = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample_trig;
    logic [DW-1:0] data_in;
    logic          bypass;
    logic          eng_start;
    logic [SW-1:0] eng_stage;
    logic [DW-1:0] eng_data_in;
    logic          eng_done;
    logic [DW-1:0] eng_data_out;
    logic [DW-1:0] data_out;
    logic          filter_done;
    logic          busy;
    logic          overrun;
    logic          timeout_err;
    logic          err_clr;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int fd_count = 0;
    int fd_cyc = 0;
    int start_count = 0;

    int exp_q[$];
    int stage_q[$];
    int sdata_q[$];
    logic [SW-1:0] held_stage;
    logic [DW-1:0] held_data;

    logic [L-1:0]  pipe;
    logic [DW-1:0] eng_res;
    logic          eng_en;

    sos_scheduler #(
        .DATA_SIZE(DW),
        .N_STAGES (NS),
        .STAGE_W  (SW),
        .TIMEOUT  (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_trig (sample_trig),
        .data_in     (data_in),
`ifdef SOS_BYPASS_EN
        .bypass      (bypass),
`endif
        .eng_start   (eng_start),
        .eng_stage   (eng_stage),
        .eng_data_in (eng_data_in),
        .eng_done    (eng_done),
        .eng_data_out(eng_data_out),
        .data_out    (data_out),
        .filter_done (filter_done),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: done arrives L cycles after start, carrying operand + 1
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe    <= '0;
            eng_res <= '0;
        end else begin
            pipe <= {pipe[L-2:0], eng_start};
            if (eng_start) eng_res <= eng_data_in + 24'd1;
        end
    end
    assign eng_done     = pipe[L-1] & eng_en;
    assign eng_data_out = eng_res;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: engine issues and filter results against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (eng_start) begin
                start_count++;
                held_stage = eng_stage;
                held_data  = eng_data_in;
                if (stage_q.size() == 0) begin
                    check_eq("start_unexp", 32'(stage_q.size()), 32'd1);
                end else begin
                    check_eq("eng_stage", 32'(eng_stage), 32'(stage_q.pop_front()));
                    check_eq("eng_data_in", 32'(eng_data_in), 32'(sdata_q.pop_front()));
                end
            end
            if (eng_done && busy) begin
                check_eq("hold_stage", 32'(eng_stage), 32'(held_stage));
                check_eq("hold_data", 32'(eng_data_in), 32'(held_data));
            end
            if (filter_done) begin
                fd_count++;
                fd_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_eq("fd_unexp", 32'(exp_q.size()), 32'd1);
                end else begin
                    check_eq("data_out", 32'(data_out), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_run(input int d);
        for (int s = 0; s < NS; s++) begin
            stage_q.push_back(s);
            sdata_q.push_back(d + s);
        end
        exp_q.push_back(d + NS);
    endtask

    task automatic trig(input logic [DW-1:0] d);
        data_in     = d;
        sample_trig = 1'b1;
        @(negedge clk);
        sample_trig = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int bound);
        int start;
        int k;
        start = fd_count;
        k = 0;
        while (fd_count == start && k < bound) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(fd_count - start), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int k;
        int fd_before;
        reset       = 1'b0;
        sample_trig = 1'b0;
        data_in     = '0;
        bypass      = 1'b0;
        err_clr     = 1'b0;
        eng_en      = 1'b1;
        tick(3);
        check_eq("rst_data_out", 32'(data_out), 32'd0);
        check_eq("rst_filter_done", 32'(filter_done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        check_eq("rst_timeout", 32'(timeout_err), 32'd0);
        check_eq("rst_eng_start", 32'(eng_start), 32'd0);
        check_eq("rst_eng_stage", 32'(eng_stage), 32'd0);
        check_eq("rst_eng_data_in", 32'(eng_data_in), 32'd0);
        reset = 1'b1;
        tick(2);

        // Nominal cascade with a dropped second sample 5 cycles in
        push_run(100);
        t0 = cyc;
        trig(24'd100);
        tick(4);
        trig(24'd50);
        check_eq("busy_mid", 32'(busy), 32'd1);
        wait_fd("fd_first", 40);
        check_eq("latency", 32'(fd_cyc - t0), 32'd17);
        check_eq("result_104", 32'(data_out), 32'd104);
        tick(20);
        check_eq("single_fd", 32'(fd_count), 32'd1);
        check_eq("overrun_set", 32'(overrun), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("still_104", 32'(data_out), 32'd104);

        // err_clr coincident with a new overrun: set wins
        push_run(200);
        trig(24'd200);
        tick(3);
        data_in     = 24'd77;
        sample_trig = 1'b1;
        err_clr     = 1'b1;
        @(negedge clk);
        sample_trig = 1'b0;
        err_clr     = 1'b0;
        check_eq("ovr_set_wins", 32'(overrun), 32'd1);
        wait_fd("fd_second", 40);
        check_eq("result_204", 32'(data_out), 32'd204);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("clr_overrun", 32'(overrun), 32'd0);
        check_eq("clr_timeout", 32'(timeout_err), 32'd0);

        // Engine never answers: timeout after 64 WAIT cycles
        eng_en = 1'b0;
        stage_q.push_back(0);
        sdata_q.push_back(9);
        fd_before = fd_count;
        t0 = cyc;
        trig(24'd9);
        k = 0;
        while (!timeout_err && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("tmo_flag", 32'(timeout_err), 32'd1);
        check_eq("tmo_latency", 32'(cyc - t0), 32'd66);
        check_eq("tmo_busy", 32'(busy), 32'd0);
        check_eq("tmo_data_out", 32'(data_out), 32'd204);
        tick(5);
        check_eq("tmo_no_fd", 32'(fd_count - fd_before), 32'd0);
        eng_en  = 1'b1;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("tmo_clr", 32'(timeout_err), 32'd0);

        // Reset in WAIT at stage 2, then a normal sample
        for (int s = 0; s < 3; s++) begin
            stage_q.push_back(s);
            sdata_q.push_back(55 + s);
        end
        trig(24'd55);
        tick(9);
        check_eq("pre_rst_stage", 32'(eng_stage), 32'd2);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_data_out", 32'(data_out), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_eng_stage", 32'(eng_stage), 32'd0);
        check_eq("mid_rst_eng_data", 32'(eng_data_in), 32'd0);
        check_eq("mid_rst_eng_start", 32'(eng_start), 32'd0);
        check_eq("mid_rst_fd", 32'(filter_done), 32'd0);
        check_eq("mid_rst_q", 32'(stage_q.size()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick(1);
        push_run(7);
        trig(24'd7);
        wait_fd("fd_after_rst", 40);
        check_eq("result_11", 32'(data_out), 32'd11);

`ifdef SOS_BYPASS_EN
        // Bypass: straight to data_out after 2 cycles, no engine activity
        k = start_count;
        exp_q.push_back(32'h123456);
        bypass = 1'b1;
        t0 = cyc;
        trig(24'h123456);
        bypass = 1'b0;
        wait_fd("fd_bypass", 10);
        check_eq("bypass_latency", 32'(fd_cyc - t0), 32'd2);
        check_eq("bypass_no_start", 32'(start_count - k), 32'd0);
`endif

        tick(3);
        check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check_eq("stage_q_empty", 32'(stage_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sos_scheduler.md
SOS_SCHEDULER -- requirements
Module: sos_scheduler

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 24, sample and engine data width.
REQ-002 SHALL have parameter N_STAGES, default 4, number of cascaded biquad sections run on one shared engine (legal range 1..2^STAGE_W).
REQ-003 SHALL have parameter STAGE_W, default 2, width of the stage index.
REQ-004 SHALL have parameter TIMEOUT, default 64, maximum cycles to wait for eng_done per stage (legal range 2..255).
REQ-005 SHALL have port clk  input  1  sole clock, all logic on the rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port sample_trig  input  1  one-cycle new-sample strobe.
REQ-008 SHALL have port data_in  input  DATA_SIZE  input sample, valid with sample_trig.
REQ-009 SHALL have port eng_start  output  1  one-cycle start strobe to the biquad engine.
REQ-010 SHALL have port eng_stage  output  STAGE_W  coefficient/state-bank select for the engine.
REQ-011 SHALL have port eng_data_in  output  DATA_SIZE  engine operand.
REQ-012 SHALL have port eng_done  input  1  engine result-valid strobe.
REQ-013 SHALL have port eng_data_out  input  DATA_SIZE  engine result, valid with eng_done.
REQ-014 SHALL have port data_out  output  DATA_SIZE  registered cascade output.
REQ-015 SHALL have port filter_done  output  1  one-cycle pulse when data_out updates.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have ports overrun and timeout_err  output  1 each  sticky error flags; err_clr  input  1  clears both.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-019 IDLE + sample_trig SHALL latch data_in into work register, set stage to 0, go to ISSUE.
REQ-020 ISSUE SHALL assert eng_start for exactly one cycle, with eng_data_in = work and eng_stage = stage, then go to WAIT; eng_done in ISSUE is ignored.
REQ-021 WAIT + eng_done SHALL latch eng_data_out into work; if stage = N_STAGES-1 go to DONE, else increment stage and go to ISSUE.
REQ-022 DONE SHALL load data_out from work, pulse filter_done for one cycle, return to IDLE.
REQ-023 Latency from sample_trig to filter_done SHALL be N_STAGES*(1+L)+1 cycles, where L >= 1 is the engine start-to-done delay.
REQ-024 eng_stage and eng_data_in SHALL hold their values from ISSUE through the end of WAIT.
REQ-025 A per-stage timeout counter SHALL clear in ISSUE and increment every WAIT cycle; reaching TIMEOUT-1 without eng_done SHALL set timeout_err and return to IDLE, leaving data_out unchanged and producing no filter_done.
REQ-026 sample_trig in any non-IDLE state SHALL set overrun and drop the sample; the sequence in progress is unaffected.
REQ-027 err_clr SHALL clear both flags; when a set and err_clr occur in the same cycle, the set SHALL win.
REQ-028 Data SHALL pass unmodified (no truncation, no saturation); arithmetic is owned by the engine.

Reset
REQ-029 Reset low SHALL force IDLE immediately, mid-sequence included; stage=0, work=0, data_out=0, eng_start=0, eng_stage=0, eng_data_in=0, filter_done=0, busy=0, overrun=0, timeout_err=0.
REQ-030 The first sample_trig after reset release SHALL be accepted normally.

Configuration
REQ-031 With macro SOS_BYPASS_EN defined, the block SHALL add input port bypass (1 bit), sampled with sample_trig; bypass=1 SHALL go IDLE->DONE directly, data_out = data_in, filter_done 2 cycles after trig, no eng_start.
REQ-032 Without SOS_BYPASS_EN, the bypass port SHALL be absent and every sample SHALL run all N_STAGES.

Verification
REQ-033 Engine model L=3 returns input+1; data_in=100, trig -> eng_stage 0,1,2,3 in order, data_out=104, filter_done at cycle 17.
REQ-034 Second trig 5 cycles after the first -> overrun=1, first result still 104, no second filter_done.
REQ-035 Engine never asserts eng_done -> timeout_err=1 after 64 WAIT cycles, busy=0, data_out unchanged.
REQ-036 err_clr and a new overrun in the same cycle -> overrun stays 1; err_clr alone -> both flags 0.
REQ-037 Reset asserted while in WAIT at stage 2 -> all outputs 0 at once; next trig with data_in=7 -> data_out=11.
REQ-038 With SOS_BYPASS_EN, bypass=1 and data_in=0x123456 -> data_out=0x123456 two cycles later, eng_start never asserted.
